// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_sequencer
// Brief   : Multi-cycle LEGv8 control FSM with handshaked memories and timeout.
// Revision: 1.0
// ============================================================================
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int RETIRE_W   = 32
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [10:0]         opcode,
    input  logic                zero,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                pcsrc,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic [3:0]          aluop,
    output logic [2:0]          signop,
    output logic [RETIRE_W-1:0] instr_retired,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ADD  = 4'd0,
        C_SUB  = 4'd1,
        C_AND  = 4'd2,
        C_ORR  = 4'd3,
        C_LDUR = 4'd4,
        C_STUR = 4'd5,
        C_CBZ  = 4'd6,
        C_B    = 4'd7,
        C_MOVZ = 4'd8,
        C_ILL  = 4'd9
    } class_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [2:0] SE_I     = 3'b000;
    localparam logic [2:0] SE_D     = 3'b001;
    localparam logic [2:0] SE_B     = 3'b010;
    localparam logic [2:0] SE_CB    = 3'b011;
    localparam logic [2:0] SE_MOVZ  = 3'b100;

    state_t              state, state_next;
    class_t              cls, cls_dec;
    logic [7:0]          wait_cnt;
    logic [RETIRE_W-1:0] retired;
    logic                timeout_flag;
    logic                set_fault;
    logic                alu_drive;
    logic                waiting;

    always_comb begin
        cls_dec = C_ILL;
        casez (opcode)
            11'b10001011000: cls_dec = C_ADD;
            11'b11001011000: cls_dec = C_SUB;
            11'b10001010000: cls_dec = C_AND;
            11'b10101010000: cls_dec = C_ORR;
            11'b11111000010: cls_dec = C_LDUR;
            11'b11111000000: cls_dec = C_STUR;
            11'b10110100???: cls_dec = C_CBZ;
            11'b000101?????: cls_dec = C_B;
            11'b110100101??: cls_dec = C_MOVZ;
            default:         cls_dec = C_ILL;
        endcase
    end

    // The counter holds the number of already-elapsed unacknowledged cycles,
    // so the current cycle is the last allowed one when it equals LIMIT-1.
    logic at_limit;
    assign at_limit = (wait_cnt == 8'(WAIT_LIMIT - 1));

    always_comb begin
        state_next = state;
        set_fault  = 1'b0;
        alu_drive  = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        mem2reg    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    irwrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (at_limit) begin
                    set_fault  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_DECODE: state_next = (cls_dec == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                alu_drive = 1'b1;
                case (cls)
                    C_B, C_CBZ: begin
                        pcwrite    = 1'b1;
                        pcsrc      = (cls == C_B) ? 1'b1 : zero;
                        state_next = S_FETCH;
                    end
                    C_LDUR, C_STUR:             state_next = S_MEM;
                    C_ADD, C_SUB, C_AND, C_ORR,
                    C_MOVZ:                     state_next = S_WB;
                    default:                    state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                alu_drive = 1'b1;
                dmem_req  = 1'b1;
                memread   = (cls == C_LDUR);
                memwrite  = (cls == C_STUR);
                if (dmem_ack) begin
                    if (cls == C_STUR) begin
                        pcwrite    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (at_limit) begin
                    set_fault  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                alu_drive  = 1'b1;
                regwrite   = 1'b1;
                pcwrite    = 1'b1;
                mem2reg    = (cls == C_LDUR);
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            pcsrc    = 1'b0;
            mem2reg  = 1'b0;
            regwrite = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            alu_drive = 1'b0;
        end
    end

    always_comb begin
        aluop   = ALU_AND;
        alusrc  = 1'b0;
        signop  = SE_I;
        reg2loc = 1'b0;
        if (alu_drive) begin
            case (cls)
                C_ADD:         aluop = ALU_ADD;
                C_SUB:         aluop = ALU_SUB;
                C_AND:         aluop = ALU_AND;
                C_ORR:         aluop = ALU_ORR;
                C_LDUR, C_STUR: begin
                    aluop  = ALU_ADD;
                    alusrc = 1'b1;
                    signop = SE_D;
                end
                C_MOVZ: begin
                    aluop  = ALU_PASS;
                    alusrc = 1'b1;
                    signop = SE_MOVZ;
                end
                C_CBZ: begin
                    aluop   = ALU_PASS;
                    reg2loc = 1'b1;
                    signop  = SE_CB;
                end
                C_B:           signop = SE_B;
                default:       aluop = ALU_AND;
            endcase
        end
    end

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && (state_next == state);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_FETCH;
            cls          <= C_ILL;
            wait_cnt     <= 8'd0;
            retired      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                cls <= cls_dec;
            end
            wait_cnt <= waiting ? (wait_cnt + 8'd1) : 8'd0;
            if (pcwrite) begin
                retired <= retired + RETIRE_W'(1);
            end
            if (set_fault) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign instr_retired = reset ? '0 : retired;
    assign halted        = !reset && (state == S_HALT);
    assign fault         = !reset && timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_sequencer
// Brief   : Directed self-checking bench for multicycle_sequencer.
// Revision: 1.0
// ============================================================================
module tb_multicycle_sequencer;

    localparam int WAIT_LIMIT = 4;
    localparam int RETIRE_W   = 4;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    logic                CLK = 1'b0;
    logic                reset, zero, imem_ack, dmem_ack;
    logic [10:0]         opcode;
    logic                imem_req, dmem_req, irwrite, pcwrite, pcsrc;
    logic                reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
    logic [3:0]          aluop;
    logic [2:0]          signop;
    logic [RETIRE_W-1:0] instr_retired;
    logic                halted, fault;
    logic [17:0]         ctl;

    int n_checks = 0;
    int n_bad    = 0;
    int pw_seen  = 0;
    int rw_seen  = 0;

    always #5 CLK = ~CLK;

    multicycle_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .RETIRE_W(RETIRE_W)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .reg2loc(reg2loc), .alusrc(alusrc),
        .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .aluop(aluop), .signop(signop),
        .instr_retired(instr_retired), .halted(halted), .fault(fault)
    );

    assign ctl = {imem_req, dmem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc,
                  mem2reg, regwrite, memread, memwrite, aluop, signop};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called mid-cycle; tallies pulses, then advances to 1ns past the next edge.
    task automatic cyc();
        if (pcwrite)  pw_seen++;
        if (regwrite) rw_seen++;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; opcode = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b0;
        pw_seen = 0;
        rw_seen = 0;
    endtask

    initial begin
        // Reset with acknowledges high: outputs must stay gated off.
        reset = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; zero = 1'b0; opcode = OP_ADD;
        @(posedge CLK); #3;
        check_val("rst_ctl", 32'(ctl), 32'd0);
        check_val("rst_cnt", 32'(instr_retired), 32'd0);
        check_val("rst_halt", {30'd0, halted, fault}, 32'd0);

        // ADD with imem_ack tied high
        do_reset(); opcode = OP_ADD; imem_ack = 1'b1;
        #2; check_val("add_c1_ireq", 32'(imem_req), 32'd1);
            check_val("add_c1_irw", 32'(irwrite), 32'd1); cyc();
        #2; check_val("add_c2_decode", 32'(ctl), 32'd0); cyc();
        #2; check_val("add_c3_aluop", 32'(aluop), 32'b0010);
            check_val("add_c3_pcw", 32'(pcwrite), 32'd0); cyc();
        #2; check_val("add_c4_wb", {pcsrc, mem2reg, regwrite, pcwrite}, 32'b0011); cyc();
        #2; check_val("add_retired", 32'(instr_retired), 32'd1);
        imem_ack = 1'b0;

        // LDUR, dmem_ack on the 4th request cycle (equals WAIT_LIMIT: ack wins)
        do_reset(); opcode = OP_LDUR; imem_ack = 1'b1;
        #2; cyc();
        #2; cyc();
        #2; check_val("ldur_exec", {aluop, alusrc, signop, dmem_req}, 32'b0010_1_001_0); cyc();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #2; check_val("ldur_mem", {dmem_req, memwrite, memread, aluop}, 32'b101_0010); cyc();
        end
        dmem_ack = 1'b0;
        #2; check_val("ldur_wb", {mem2reg, regwrite, pcwrite, dmem_req}, 32'b1110); cyc();
        #2; check_val("ldur_retired", 32'(instr_retired), 32'd1);
            check_val("ldur_nohalt", {halted, fault, imem_req}, 32'b001);
        imem_ack = 1'b0;

        // CBZ taken then not taken
        do_reset(); opcode = OP_CBZ; imem_ack = 1'b1; zero = 1'b1;
        #2; cyc();
        #2; cyc();
        #2; check_val("cbz1_exec", {pcwrite, pcsrc, reg2loc, aluop, signop}, 32'b1_1_1_0111_011); cyc();
        zero = 1'b0;
        #2; check_val("cbz2_fetch", 32'(irwrite), 32'd1); cyc();
        #2; cyc();
        #2; check_val("cbz2_exec", {pcwrite, pcsrc}, 32'b10); cyc();
        #2; check_val("cbz_retired", 32'(instr_retired), 32'd2);
            check_val("cbz_regwrite", rw_seen, 32'd0);
            check_val("cbz_pcwrite", pw_seen, 32'd2);
        imem_ack = 1'b0;

        // Illegal opcode halts without fault
        do_reset(); opcode = OP_ILL; imem_ack = 1'b1; dmem_ack = 1'b1;
        #2; cyc();
        #2; cyc();
        for (int i = 0; i < 4; i++) begin
            #2; check_val("ill_halt", {halted, fault}, 32'b10);
                check_val("ill_ctl", 32'(ctl), 32'd0); cyc();
        end

        // Fetch timeout after WAIT_LIMIT cycles
        do_reset(); opcode = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            #2; check_val("to_wait", {imem_req, halted}, 32'b10); cyc();
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 1);
            #2; check_val("to_halt", {halted, fault}, 32'b11);
                check_val("to_ctl", 32'(ctl), 32'd0); cyc();
        end
        do_reset();
        #2; check_val("to_exit", {halted, fault, imem_req}, 32'b001);

        // Reset during STUR memory access, then a late dmem_ack
        do_reset(); opcode = OP_ADD; imem_ack = 1'b1;
        #2; cyc();
        #2; cyc();
        #2; cyc();
        opcode = OP_STUR;
        #2; cyc();
        #2; cyc();
        #2; cyc();
        #2; cyc();
        imem_ack = 1'b0;
        #2; check_val("stur_mem", {dmem_req, memwrite, memread}, 32'b110);
            check_val("stur_cnt", 32'(instr_retired), 32'd1); cyc();
        reset = 1'b1;
        #2; check_val("stur_rst_ctl", 32'(ctl), 32'd0); cyc();
        reset = 1'b0; dmem_ack = 1'b1;
        #2; check_val("stur_after", {imem_req, dmem_req, memwrite}, 32'b100);
            check_val("stur_after_cnt", 32'(instr_retired), 32'd0); cyc();
        #2; check_val("stur_late_ack", {imem_req, dmem_req, memwrite, halted}, 32'b1000);
            check_val("stur_late_cnt", 32'(instr_retired), 32'd0); cyc();
        dmem_ack = 1'b0;

        // 17 branches wrap a 4-bit counter to 1
        do_reset(); opcode = OP_B; imem_ack = 1'b1;
        for (int i = 0; i < 51; i++) begin
            #2;
            if (i % 3 == 2) check_val("b_exec", {pcwrite, pcsrc, signop}, 32'b11_010);
            cyc();
        end
        #2; check_val("wrap_cnt", 32'(instr_retired), 32'd1);
            check_val("wrap_pcw", pw_seen, 32'd17);
            check_val("wrap_rw", rw_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
